// File: rtl/row_to_block_stream.sv
// row_to_block_stream
// Collects eight row beats of an 8x8 coefficient block (8 coefficients each)
// into one 64-coefficient block beat. Two block slots form a ping-pong
// buffer. One slot fills at one row per cycle while the other slot waits
// for the downstream stage.
// Block layout: row r, coefficient c sits at coefficient index 8*r+c, so row r
// occupies bits [(r+1)*8*COEF_WIDTH-1 : r*8*COEF_WIDTH] of the block beat.
// Every output is a flop. Each flop is loaded from the next-state values of
// the slot machinery, so out_t_valid_o rises on the cycle after the closing
// row is accepted.

module row_to_block_stream #(
  parameter int COEF_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // row input stream
  input  logic                      in_t_valid_i,
  output logic                      in_t_ready_o,
  input  logic [8*COEF_WIDTH-1:0]   in_t_data_i,
  input  logic                      in_t_last_i,
  input  logic [ID_WIDTH-1:0]       in_t_id_i,
  input  logic [DEST_WIDTH-1:0]     in_t_dest_i,
  input  logic [USER_WIDTH-1:0]     in_t_user_i,
  // block output stream
  output logic                      out_t_valid_o,
  input  logic                      out_t_ready_i,
  output logic [64*COEF_WIDTH-1:0]  out_t_data_o,
  output logic                      out_t_last_o,
  output logic [ID_WIDTH-1:0]       out_t_id_o,
  output logic [DEST_WIDTH-1:0]     out_t_dest_o,
  output logic [USER_WIDTH-1:0]     out_t_user_o,
  output logic [8*COEF_WIDTH-1:0]   out_t_keep_o,
  output logic [8*COEF_WIDTH-1:0]   out_t_strb_o
);

  localparam int ROW_W = 8 * COEF_WIDTH;

  // slot bookkeeping
  logic [2:0]                        wr_row_q, wr_row_d;
  logic                              wr_slot_q, wr_slot_d;
  logic                              rd_slot_q, rd_slot_d;
  logic [1:0]                        full_q, full_d;

  // slot storage: [slot][row][row bits]
  logic [1:0][7:0][ROW_W-1:0]        slot_data_q, slot_data_d;
  logic [1:0]                        slot_last_q, slot_last_d;
  logic [1:0][ID_WIDTH-1:0]          slot_id_q, slot_id_d;
  logic [1:0][DEST_WIDTH-1:0]        slot_dest_q, slot_dest_d;
  logic [1:0][USER_WIDTH-1:0]        slot_user_q, slot_user_d;

  // output registers
  logic                              in_ready_q, in_ready_d;
  logic                              out_valid_q, out_valid_d;
  logic [7:0][ROW_W-1:0]             out_data_q, out_data_d;
  logic                              out_last_q, out_last_d;
  logic [ID_WIDTH-1:0]               out_id_q, out_id_d;
  logic [DEST_WIDTH-1:0]             out_dest_q, out_dest_d;
  logic [USER_WIDTH-1:0]             out_user_q, out_user_d;

  // handshake qualifiers
  logic                              row_accept_s;
  logic                              blk_drain_s;

  // Next state: write rows into the fill slot, release and clear the drain slot
  always_comb begin
    wr_row_d    = wr_row_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    full_d      = full_q;
    slot_data_d = slot_data_q;
    slot_last_d = slot_last_q;
    slot_id_d   = slot_id_q;
    slot_dest_d = slot_dest_q;
    slot_user_d = slot_user_q;

    // in_ready_q mirrors !full_q[wr_slot_q]; out_valid_q mirrors full_q[rd_slot_q]
    row_accept_s = in_t_valid_i && in_ready_q;
    blk_drain_s  = out_valid_q && out_t_ready_i;

    // A drained slot is wiped. A later short block then reads zeros in
    // the rows it never writes.
    if (blk_drain_s) begin
      full_d[rd_slot_q]      = 1'b0;
      slot_data_d[rd_slot_q] = '0;
      slot_last_d[rd_slot_q] = 1'b0;
      slot_id_d[rd_slot_q]   = {ID_WIDTH{1'b0}};
      slot_dest_d[rd_slot_q] = {DEST_WIDTH{1'b0}};
      slot_user_d[rd_slot_q] = {USER_WIDTH{1'b0}};
      rd_slot_d              = ~rd_slot_q;
    end else begin
      rd_slot_d              = rd_slot_q;
    end

    // The fill slot is never full when a row is accepted. Because of that,
    // it cannot be the slot being drained in the same cycle.
    if (row_accept_s) begin
      slot_data_d[wr_slot_q][wr_row_q] = in_t_data_i;
      if (wr_row_q == 3'd0) begin
        slot_id_d[wr_slot_q]   = in_t_id_i;
        slot_dest_d[wr_slot_q] = in_t_dest_i;
        slot_user_d[wr_slot_q] = in_t_user_i;
      end else begin
        slot_id_d[wr_slot_q]   = slot_id_q[wr_slot_q];
        slot_dest_d[wr_slot_q] = slot_dest_q[wr_slot_q];
        slot_user_d[wr_slot_q] = slot_user_q[wr_slot_q];
      end
      if ((wr_row_q == 3'd7) || in_t_last_i) begin
        full_d[wr_slot_q]      = 1'b1;
        slot_last_d[wr_slot_q] = in_t_last_i;
        wr_slot_d              = ~wr_slot_q;
        wr_row_d               = 3'd0;
      end else begin
        wr_row_d               = wr_row_q + 3'd1;
      end
    end else begin
      wr_row_d = wr_row_q;
    end

    // Outputs are loaded from next state, so they track the slots with no extra cycle
    in_ready_d  = ~full_d[wr_slot_d];
    out_valid_d = full_d[rd_slot_d];
    out_data_d  = slot_data_d[rd_slot_d];
    out_last_d  = slot_last_d[rd_slot_d];
    out_id_d    = slot_id_d[rd_slot_d];
    out_dest_d  = slot_dest_d[rd_slot_d];
    out_user_d  = slot_user_d[rd_slot_d];
  end

  // State and output registers; asynchronous reset discards all slot contents
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_row_q    <= 3'd0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      full_q      <= 2'b00;
      slot_data_q <= '0;
      slot_last_q <= 2'b00;
      slot_id_q   <= '0;
      slot_dest_q <= '0;
      slot_user_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= {ID_WIDTH{1'b0}};
      out_dest_q  <= {DEST_WIDTH{1'b0}};
      out_user_q  <= {USER_WIDTH{1'b0}};
    end else begin
      wr_row_q    <= wr_row_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      full_q      <= full_d;
      slot_data_q <= slot_data_d;
      slot_last_q <= slot_last_d;
      slot_id_q   <= slot_id_d;
      slot_dest_q <= slot_dest_d;
      slot_user_q <= slot_user_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      out_dest_q  <= out_dest_d;
      out_user_q  <= out_user_d;
    end
  end

  assign in_t_ready_o  = in_ready_q;
  assign out_t_valid_o = out_valid_q;
  assign out_t_data_o  = out_data_q;
  assign out_t_last_o  = out_last_q;
  assign out_t_id_o    = out_id_q;
  assign out_t_dest_o  = out_dest_q;
  assign out_t_user_o  = out_user_q;
  assign out_t_keep_o  = {ROW_W{1'b1}};
  assign out_t_strb_o  = {ROW_W{1'b1}};

endmodule

// File: tb/tb_row_to_block_stream.sv
// Testbench for row_to_block_stream. The reference model assembles blocks
// from accepted rows with plain arrays and pushes each finished block into
// a queue. A monitor pops the queue and compares on every output handshake.
// Inputs change 1 time unit after the rising edge. Handshakes are sampled
// on the falling edge.

module tb_row_to_block_stream;

  localparam int CW    = 32;
  localparam int IDW   = 4;
  localparam int DW    = 4;
  localparam int UW    = 4;
  localparam int ROW_W = 8 * CW;
  localparam int BLK_W = 64 * CW;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              in_t_valid_i = 1'b0;
  logic              in_t_ready_o;
  logic [ROW_W-1:0]  in_t_data_i = '0;
  logic              in_t_last_i = 1'b0;
  logic [IDW-1:0]    in_t_id_i = '0;
  logic [DW-1:0]     in_t_dest_i = '0;
  logic [UW-1:0]     in_t_user_i = '0;
  logic              out_t_valid_o;
  logic              out_t_ready_i = 1'b0;
  logic [BLK_W-1:0]  out_t_data_o;
  logic              out_t_last_o;
  logic [IDW-1:0]    out_t_id_o;
  logic [DW-1:0]     out_t_dest_o;
  logic [UW-1:0]     out_t_user_o;
  logic [ROW_W-1:0]  out_t_keep_o;
  logic [ROW_W-1:0]  out_t_strb_o;

  always #5 aclk = ~aclk;

  row_to_block_stream #(
    .COEF_WIDTH (CW),
    .ID_WIDTH   (IDW),
    .DEST_WIDTH (DW),
    .USER_WIDTH (UW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .in_t_valid_i  (in_t_valid_i),
    .in_t_ready_o  (in_t_ready_o),
    .in_t_data_i   (in_t_data_i),
    .in_t_last_i   (in_t_last_i),
    .in_t_id_i     (in_t_id_i),
    .in_t_dest_i   (in_t_dest_i),
    .in_t_user_i   (in_t_user_i),
    .out_t_valid_o (out_t_valid_o),
    .out_t_ready_i (out_t_ready_i),
    .out_t_data_o  (out_t_data_o),
    .out_t_last_o  (out_t_last_o),
    .out_t_id_o    (out_t_id_o),
    .out_t_dest_o  (out_t_dest_o),
    .out_t_user_o  (out_t_user_o),
    .out_t_keep_o  (out_t_keep_o),
    .out_t_strb_o  (out_t_strb_o)
  );

  typedef struct {
    logic [BLK_W-1:0] data;
    logic             last;
    logic [IDW-1:0]   id;
    logic [DW-1:0]    dest;
    logic [UW-1:0]    user;
  } blk_t;

  blk_t             exp_q[$];
  blk_t             mon_e;
  int               checks = 0;
  int               failures = 0;
  int               blocks_seen = 0;

  // model assembly state
  logic [BLK_W-1:0] asm_data = '0;
  int               asm_rows = 0;
  logic [IDW-1:0]   asm_id = '0;
  logic [DW-1:0]    asm_dest = '0;
  logic [UW-1:0]    asm_user = '0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    int bad;
    bad = -1;
    for (int i = 63; i >= 0; i--) begin
      if (act[i*CW +: CW] !== exp[i*CW +: CW]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: coefficient %0d got 0x%0h want 0x%0h", name, bad,
               act[bad*CW +: CW], exp[bad*CW +: CW]);
    end
  endtask

  // Monitor plus reference model: block assembly from accepted rows, compare on drain
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      asm_rows = 0;
      asm_data = '0;
    end else begin
      if (out_t_valid_o && out_t_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block: got an output beat, want none pending");
        end else begin
          mon_e = exp_q.pop_front();
          check_blk("blk_data", out_t_data_o, mon_e.data);
          check_val("blk_last", 64'(out_t_last_o), 64'(mon_e.last));
          check_val("blk_id", 64'(out_t_id_o), 64'(mon_e.id));
          check_val("blk_dest", 64'(out_t_dest_o), 64'(mon_e.dest));
          check_val("blk_user", 64'(out_t_user_o), 64'(mon_e.user));
          check_val("blk_keep_strb", 64'(&out_t_keep_o && &out_t_strb_o), 64'd1);
          blocks_seen++;
        end
      end
      if (in_t_valid_i && in_t_ready_o) begin
        if (asm_rows == 0) begin
          asm_id   = in_t_id_i;
          asm_dest = in_t_dest_i;
          asm_user = in_t_user_i;
        end
        asm_data[asm_rows*ROW_W +: ROW_W] = in_t_data_i;
        asm_rows++;
        if (asm_rows == 8 || in_t_last_i) begin
          exp_q.push_back('{data: asm_data, last: in_t_last_i, id: asm_id,
                            dest: asm_dest, user: asm_user});
          asm_rows = 0;
          asm_data = '0;
        end
      end
    end
  end

  function automatic logic [ROW_W-1:0] seq_row(input int r);
    logic [ROW_W-1:0] row;
    for (int c = 0; c < 8; c++) row[c*CW +: CW] = 32'(8*r + c);
    return row;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] row;
    for (int c = 0; c < 8; c++) row[c*CW +: CW] = $urandom();
    return row;
  endfunction

  // Present one row and hold it until accepted (bounded)
  task automatic send_row(input logic [ROW_W-1:0] d, input logic l,
                          input logic [IDW-1:0] id, input logic [DW-1:0] dest,
                          input logic [UW-1:0] user);
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    in_t_valid_i = 1'b1;
    in_t_data_i  = d;
    in_t_last_i  = l;
    in_t_id_i    = id;
    in_t_dest_i  = dest;
    in_t_user_i  = user;
    while (!rdy && n < 200) begin
      @(negedge aclk);
      rdy = in_t_ready_o;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_t_ready=0 for 200 cycles, want acceptance");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Let every pending block drain and confirm nothing is left over
  task automatic wait_drain();
    int n;
    n = 0;
    in_t_valid_i  = 1'b0;
    out_t_ready_i = 1'b1;
    while ((exp_q.size() != 0 || out_t_valid_o) && n < 200) begin
      cycles(1);
      n++;
    end
    cycles(1);
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
    check_val("drain_valid_low", 64'(out_t_valid_o), 64'd0);
  endtask

  logic [BLK_W-1:0] exp_blk;
  logic [ROW_W-1:0] rows3 [3];
  logic [ROW_W-1:0] row17;
  int               seen_before;
  int               blocks_issued;
  int               stim_rows;
  int               cyc;
  bit               acc;

  initial begin
    // reset state
    cycles(3);
    check_val("rst_in_ready", 64'(in_t_ready_o), 64'd1);
    check_val("rst_out_valid", 64'(out_t_valid_o), 64'd0);
    check_val("rst_out_last", 64'(out_t_last_o), 64'd0);
    check_blk("rst_out_data", out_t_data_o, '0);
    aresetn = 1'b1;
    cycles(2);

    // sequential fill, index i carries value i
    out_t_ready_i = 1'b1;
    for (int r = 0; r < 8; r++) begin
      send_row(seq_row(r), 1'b0, 4'd0, 4'd0, 4'd0);
      if (r == 6) check_val("fill_valid_early", 64'(out_t_valid_o), 64'd0);
    end
    in_t_valid_i = 1'b0;
    for (int i = 0; i < 64; i++) exp_blk[i*CW +: CW] = 32'(i);
    check_val("fill_latency", 64'(out_t_valid_o), 64'd1);
    check_blk("fill_index", out_t_data_o, exp_blk);
    check_val("fill_last", 64'(out_t_last_o), 64'd0);
    wait_drain();

    // back-pressure: 16 rows fill both slots, row 17 stalls
    seen_before = blocks_seen;
    out_t_ready_i = 1'b0;
    for (int r = 0; r < 16; r++) send_row(rand_row(), 1'b0, 4'(r), 4'd1, 4'd2);
    check_val("bp_ready_low", 64'(in_t_ready_o), 64'd0);
    check_val("bp_valid", 64'(out_t_valid_o), 64'd1);
    row17 = rand_row();
    in_t_valid_i = 1'b1;
    in_t_data_i  = row17;
    in_t_last_i  = 1'b0;
    cycles(4);
    check_val("bp_ready_held", 64'(in_t_ready_o), 64'd0);
    out_t_ready_i = 1'b1;
    send_row(row17, 1'b0, 4'd9, 4'd3, 4'd4);
    for (int r = 1; r < 8; r++) send_row(rand_row(), 1'b0, 4'd0, 4'd0, 4'd0);
    wait_drain();
    check_val("bp_block_count", 64'(blocks_seen - seen_before), 64'd3);

    // short block: t_last on row 2
    out_t_ready_i = 1'b0;
    exp_blk = '0;
    for (int r = 0; r < 3; r++) begin
      rows3[r] = rand_row();
      exp_blk[r*ROW_W +: ROW_W] = rows3[r];
      send_row(rows3[r], (r == 2), 4'd3, 4'd3, 4'd3);
    end
    in_t_valid_i = 1'b0;
    check_val("short_valid", 64'(out_t_valid_o), 64'd1);
    check_val("short_last", 64'(out_t_last_o), 64'd1);
    check_blk("short_data", out_t_data_o, exp_blk);
    wait_drain();

    // sideband comes from row 0
    out_t_ready_i = 1'b0;
    for (int r = 0; r < 8; r++)
      send_row(rand_row(), 1'b0, (r == 0) ? 4'd5 : 4'(r + 7),
               4'($urandom_range(0, 15)), (r == 0) ? 4'hA : 4'(r));
    in_t_valid_i = 1'b0;
    check_val("sb_id", 64'(out_t_id_o), 64'd5);
    check_val("sb_user", 64'(out_t_user_o), 64'hA);
    check_val("sb_keep", 64'(&out_t_keep_o), 64'd1);
    wait_drain();

    // reset with one full slot and four rows pending
    out_t_ready_i = 1'b0;
    for (int r = 0; r < 12; r++) send_row(rand_row(), 1'b0, 4'd1, 4'd1, 4'd1);
    in_t_valid_i = 1'b0;
    check_val("pre_reset_valid", 64'(out_t_valid_o), 64'd1);
    aresetn = 1'b0;
    #1;
    check_val("reset_valid_now", 64'(out_t_valid_o), 64'd0);
    check_val("reset_ready_now", 64'(in_t_ready_o), 64'd1);
    cycles(2);
    aresetn = 1'b1;
    cycles(1);
    seen_before = blocks_seen;
    out_t_ready_i = 1'b1;
    for (int r = 0; r < 8; r++) send_row(rand_row(), 1'b0, 4'd6, 4'd6, 4'd6);
    wait_drain();
    check_val("reset_one_block", 64'(blocks_seen - seen_before), 64'd1);

    // random stress: 1000 blocks, 50% valid and ready
    seen_before   = blocks_seen;
    blocks_issued = 0;
    stim_rows     = 0;
    cyc           = 0;
    in_t_valid_i  = 1'b0;
    while (blocks_issued < 1000 && cyc < 80000) begin
      out_t_ready_i = 1'($urandom_range(0, 1));
      if (!in_t_valid_i && $urandom_range(0, 1) == 1) begin
        in_t_valid_i = 1'b1;
        in_t_data_i  = rand_row();
        in_t_last_i  = ($urandom_range(0, 7) == 0);
        in_t_id_i    = 4'($urandom_range(0, 15));
        in_t_dest_i  = 4'($urandom_range(0, 15));
        in_t_user_i  = 4'($urandom_range(0, 15));
      end
      @(negedge aclk);
      acc = in_t_valid_i && in_t_ready_o;
      @(posedge aclk);
      #1;
      cyc++;
      if (acc) begin
        stim_rows++;
        if (stim_rows == 8 || in_t_last_i) begin
          blocks_issued++;
          stim_rows = 0;
        end
        in_t_valid_i = 1'b0;
      end
    end
    wait_drain();
    check_val("stress_blocks", 64'(blocks_seen - seen_before), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
